// File: rtl/handshake_pipeline.sv
// D-stage valid/ready pipeline (bypass, forward-registered or skid slices) with occupancy count.
// Latency D cycles; backpressure: MODE 1 ready ripples combinationally, MODE 2 ready is registered per stage.
module handshake_pipeline #(
  parameter int W    = 32,
  parameter int D    = 2,
  parameter int MODE = 2,
  localparam int CW  = (D < 1) ? 1 : $clog2(2 * D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data,
  output logic [CW-1:0] occupancy
);

  typedef enum logic [1:0] {S_EMPTY, S_BUSY, S_FULL} state_t;

  generate
    if (D == 0 || MODE == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign s_ready   = m_ready;
      assign m_valid   = s_valid;
      assign m_data    = s_data;
      assign occupancy = '0;
    end else begin : g_pipe
      logic [D-1:0]  vld_q;
      logic [W-1:0]  dat_q [D];
      logic [D-1:0]  in_vld;
      logic [D-1:0]  in_rdy;
      logic [D-1:0]  out_rdy;
      logic [D-1:0]  in_hs;
      logic [D-1:0]  out_hs;
      logic [W-1:0]  in_dat [D];
      logic [CW-1:0] occ_q;
      logic [CW-1:0] occ_d;
      logic          s_hs;
      logic          m_hs;

      for (genvar i = 0; i < D; i++) begin : g_link
        if (i == 0) begin : g_head
          assign in_vld[i] = s_valid;
          assign in_dat[i] = s_data;
        end else begin : g_mid
          assign in_vld[i] = vld_q[i-1];
          assign in_dat[i] = dat_q[i-1];
        end
        if (i == D - 1) begin : g_tail
          assign out_rdy[i] = m_ready;
        end else begin : g_next
          assign out_rdy[i] = in_rdy[i+1];
        end
      end

      assign in_hs  = in_vld & in_rdy;
      assign out_hs = vld_q & out_rdy;

      assign s_ready   = in_rdy[0];
      assign m_valid   = vld_q[D-1];
      assign m_data    = dat_q[D-1];
      assign occupancy = occ_q;

      assign s_hs = s_valid & s_ready;
      assign m_hs = m_valid & m_ready;

      always_comb begin
        occ_d = occ_q;
        if (s_hs && !m_hs) begin
          occ_d = occ_q + CW'(1);
        end else if (!s_hs && m_hs) begin
          occ_d = occ_q - CW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          occ_q <= '0;
        end else begin
          occ_q <= occ_d;
        end
      end

      if (MODE == 1) begin : g_fwd
        // Ready ripples back from m_ready through every stage that is holding a beat.
        always_comb begin : p_ready_chain
          logic r;
          in_rdy = '0;
          r      = m_ready;
          for (int i = D - 1; i >= 0; i--) begin
            r         = ~vld_q[i] | r;
            in_rdy[i] = r;
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < D; i++) begin
              dat_q[i] <= '0;
            end
          end else begin
            for (int i = 0; i < D; i++) begin
              if (in_hs[i]) begin
                dat_q[i] <= in_dat[i];
                vld_q[i] <= 1'b1;
              end else if (out_hs[i]) begin
                vld_q[i] <= 1'b0;
              end
            end
          end
        end
      end else begin : g_skid
        state_t       st_q   [D];
        logic [W-1:0] skid_q [D];
        logic [D-1:0] rdy_q;

        assign in_rdy = rdy_q;

        // rdy_q tracks "next state is not FULL", so it is low through reset and rises one edge later.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_q <= '0;
            rdy_q <= '0;
            for (int i = 0; i < D; i++) begin
              st_q[i]   <= S_EMPTY;
              dat_q[i]  <= '0;
              skid_q[i] <= '0;
            end
          end else begin
            for (int i = 0; i < D; i++) begin
              case (st_q[i])
                S_EMPTY: begin
                  rdy_q[i] <= 1'b1;
                  if (in_hs[i]) begin
                    st_q[i]  <= S_BUSY;
                    dat_q[i] <= in_dat[i];
                    vld_q[i] <= 1'b1;
                  end
                end
                S_BUSY: begin
                  if (in_hs[i] && out_hs[i]) begin
                    dat_q[i] <= in_dat[i];
                  end else if (in_hs[i]) begin
                    st_q[i]   <= S_FULL;
                    skid_q[i] <= in_dat[i];
                    rdy_q[i]  <= 1'b0;
                  end else if (out_hs[i]) begin
                    st_q[i]  <= S_EMPTY;
                    vld_q[i] <= 1'b0;
                  end
                end
                S_FULL: begin
                  if (out_hs[i]) begin
                    st_q[i]  <= S_BUSY;
                    dat_q[i] <= skid_q[i];
                    rdy_q[i] <= 1'b1;
                  end
                end
                default: begin
                  st_q[i]  <= S_EMPTY;
                  vld_q[i] <= 1'b0;
                  rdy_q[i] <= 1'b1;
                end
              endcase
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_handshake_pipeline.sv
// Directed bench for handshake_pipeline across skid, forward-registered and pass-through configurations.
module tb_handshake_pipeline;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // A: D=2 MODE=2
  logic a_sv, a_sr, a_mv, a_mr;
  logic [31:0] a_sd, a_md;
  logic [2:0]  a_occ;
  // B: D=3 MODE=1
  logic b_sv, b_sr, b_mv, b_mr;
  logic [15:0] b_sd, b_md;
  logic [2:0]  b_occ;
  // C: D=0
  logic c_sv, c_sr, c_mv, c_mr;
  logic [31:0] c_sd, c_md;
  logic [0:0]  c_occ;
  // E: D=4 MODE=0
  logic e_sv, e_sr, e_mv, e_mr;
  logic [31:0] e_sd, e_md;
  logic [3:0]  e_occ;
  // F: D=4 MODE=2
  logic f_sv, f_sr, f_mv, f_mr;
  logic [31:0] f_sd, f_md;
  logic [3:0]  f_occ;

  handshake_pipeline #(.W(32), .D(2), .MODE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
    .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md), .occupancy(a_occ));
  handshake_pipeline #(.W(16), .D(3), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
    .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md), .occupancy(b_occ));
  handshake_pipeline #(.W(32), .D(0), .MODE(2)) u_c (
    .clk(clk), .rst_n(rst_n), .s_valid(c_sv), .s_ready(c_sr), .s_data(c_sd),
    .m_valid(c_mv), .m_ready(c_mr), .m_data(c_md), .occupancy(c_occ));
  handshake_pipeline #(.W(32), .D(4), .MODE(0)) u_e (
    .clk(clk), .rst_n(rst_n), .s_valid(e_sv), .s_ready(e_sr), .s_data(e_sd),
    .m_valid(e_mv), .m_ready(e_mr), .m_data(e_md), .occupancy(e_occ));
  handshake_pipeline #(.W(32), .D(4), .MODE(2)) u_f (
    .clk(clk), .rst_n(rst_n), .s_valid(f_sv), .s_ready(f_sr), .s_data(f_sd),
    .m_valid(f_mv), .m_ready(f_mr), .m_data(f_md), .occupancy(f_occ));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    n_checks++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", a_mv); end
    n_checks++; if (a_md !== 32'h0) begin n_fail++; $display("FAIL rst_m_data: got %h want 0", a_md); end
    n_checks++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", a_occ); end
    n_checks++; if (a_sr !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready_m2: got %b want 0", a_sr); end
    n_checks++; if (f_sr !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready_d4: got %b want 0", f_sr); end
    n_checks++; if (b_mv !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid_m1: got %b want 0", b_mv); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    n_checks++; if (a_sr !== 1'b0) begin n_fail++; $display("FAIL deassert_s_ready_low: got %b want 0", a_sr); end
    n_checks++; if (b_sr !== 1'b1) begin n_fail++; $display("FAIL m1_s_ready_after_rst: got %b want 1", b_sr); end
    tick;
    #3;
    n_checks++; if (a_sr !== 1'b1) begin n_fail++; $display("FAIL first_edge_s_ready: got %b want 1", a_sr); end
    n_checks++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL post_rst_occ: got %0d want 0", a_occ); end
  endtask

  task automatic test_back_to_back;
    int peak;
    int acc, emi, eocc;
    logic ev;
    peak = 0;
    a_mr = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick;
      a_sv = (c < 8);
      a_sd = 32'(c + 1);
      #3;
      ev   = (c >= 2 && c < 10);
      acc  = (c < 8) ? c : 8;
      emi  = (c < 2) ? 0 : ((c - 2 > 8) ? 8 : c - 2);
      eocc = acc - emi;
      n_checks++; if (a_mv !== ev) begin n_fail++; $display("FAIL b2b_m_valid c=%0d: got %b want %b", c, a_mv, ev); end
      if (ev) begin
        n_checks++; if (a_md !== 32'(c - 1)) begin n_fail++; $display("FAIL b2b_m_data c=%0d: got %h want %h", c, a_md, 32'(c - 1)); end
      end
      if (c < 8) begin
        n_checks++; if (a_sr !== 1'b1) begin n_fail++; $display("FAIL b2b_s_ready c=%0d: got %b want 1", c, a_sr); end
      end
      n_checks++; if (a_occ !== 3'(eocc)) begin n_fail++; $display("FAIL b2b_occ c=%0d: got %0d want %0d", c, a_occ, eocc); end
      if (int'(a_occ) > peak) peak = int'(a_occ);
    end
    n_checks++; if (peak !== 2) begin n_fail++; $display("FAIL b2b_peak_occ: got %0d want 2", peak); end
  endtask

  task automatic test_stall;
    int n, k;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      a_mr = 1'b0;
      a_sv = 1'b1;
      a_sd = 32'hA0 + 32'(n);
      #3;
      n_checks++; if (a_sr !== (c < 4)) begin n_fail++; $display("FAIL stall_s_ready c=%0d: got %b want %b", c, a_sr, (c < 4)); end
      if (c >= 2) begin
        n_checks++; if (a_mv !== 1'b1 || a_md !== 32'hA0) begin n_fail++; $display("FAIL stall_hold c=%0d: got v=%b d=%h want v=1 d=a0", c, a_mv, a_md); end
      end
      if (a_sv && a_sr) n++;
    end
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL stall_accepted: got %0d want 4", n); end
    n_checks++; if (a_occ !== 3'd4) begin n_fail++; $display("FAIL stall_occ: got %0d want 4", a_occ); end
    k = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      a_sv = 1'b0;
      a_mr = 1'b1;
      #3;
      if (a_mv) begin
        n_checks++; if (a_md !== 32'hA0 + 32'(k)) begin n_fail++; $display("FAIL drain_data k=%0d: got %h want %h", k, a_md, 32'hA0 + 32'(k)); end
        k++;
      end
    end
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL drain_count: got %0d want 4", k); end
    n_checks++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL drain_occ: got %0d want 0", a_occ); end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 6; c++) begin
      tick;
      a_sv = 1'b1;
      a_mr = 1'b0;
      a_sd = 32'hC0 + 32'(c);
    end
    tick;
    a_sv = 1'b0;
    #3;
    n_checks++; if (a_occ !== 3'd4) begin n_fail++; $display("FAIL fill_occ: got %0d want 4", a_occ); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL async_m_valid: got %b want 0", a_mv); end
    n_checks++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL async_occ: got %0d want 0", a_occ); end
    n_checks++; if (a_sr !== 1'b0) begin n_fail++; $display("FAIL async_s_ready: got %b want 0", a_sr); end
    tick;
    tick;
    rst_n = 1'b1;
    #3;
    n_checks++; if (a_sr !== 1'b0) begin n_fail++; $display("FAIL mid_deassert_s_ready: got %b want 0", a_sr); end
    tick;
    #3;
    n_checks++; if (a_sr !== 1'b1) begin n_fail++; $display("FAIL mid_first_edge_s_ready: got %b want 1", a_sr); end
    a_sv = 1'b1;
    a_sd = 32'h55;
    a_mr = 1'b1;
    tick;
    a_sv = 1'b0;
    #3;
    n_checks++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL x55_early: got %b want 0", a_mv); end
    tick;
    #3;
    n_checks++; if (a_mv !== 1'b1 || a_md !== 32'h55) begin n_fail++; $display("FAIL x55_out: got v=%b d=%h want v=1 d=55", a_mv, a_md); end
    tick;
    #3;
    n_checks++; if (a_mv !== 1'b0 || a_occ !== 3'd0) begin n_fail++; $display("FAIL x55_after: got v=%b occ=%0d want v=0 occ=0", a_mv, a_occ); end
  endtask

  task automatic test_passthrough;
    logic ev, er;
    logic [31:0] ed, fd;
    for (int i = 0; i < 8; i++) begin
      tick;
      ev = 1'((i >> 0) & 1);
      er = 1'((i >> 1) & 1) ^ ev;
      ed = 32'h1111_0000 + 32'(i * 7);
      fd = 32'hBEEF_0000 ^ 32'(i);
      c_sv = ev; c_mr = er; c_sd = ed;
      e_sv = er; e_mr = ev; e_sd = fd;
      #1;
      n_checks++; if (c_mv !== ev || c_sr !== er || c_md !== ed || c_occ !== 1'b0) begin
        n_fail++; $display("FAIL d0_pass i=%0d: got v=%b r=%b d=%h o=%0d want v=%b r=%b d=%h o=0", i, c_mv, c_sr, c_md, c_occ, ev, er, ed);
      end
      n_checks++; if (e_mv !== er || e_sr !== ev || e_md !== fd || e_occ !== 4'd0) begin
        n_fail++; $display("FAIL m0_pass i=%0d: got v=%b r=%b d=%h o=%0d want v=%b r=%b d=%h o=0", i, e_mv, e_sr, e_md, e_occ, er, ev, fd);
      end
    end
    c_sv = 1'b0; c_mr = 1'b0; e_sv = 1'b0; e_mr = 1'b0;
  endtask

  task automatic test_random_mode1;
    int tx, rx, cyc;
    logic prev_stall;
    logic [15:0] prev_d;
    void'($urandom(32'd20240611));
    tx = 0; rx = 0; cyc = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    while (rx < 10000 && cyc < 60000) begin
      tick;
      cyc++;
      b_sv = ($urandom_range(3) != 0);
      b_mr = ($urandom_range(3) != 0);
      b_sd = 16'(tx);
      #3;
      if (prev_stall) begin
        n_checks++; if (b_mv !== 1'b1 || b_md !== prev_d) begin n_fail++; $display("FAIL m1_stable cyc=%0d: got v=%b d=%h want v=1 d=%h", cyc, b_mv, b_md, prev_d); end
      end
      n_checks++; if (b_occ !== 3'(tx - rx) || b_occ > 3'd3) begin n_fail++; $display("FAIL m1_occ cyc=%0d: got %0d want %0d", cyc, b_occ, tx - rx); end
      if (b_mv && b_mr) begin
        n_checks++; if (b_md !== 16'(rx)) begin n_fail++; $display("FAIL m1_order: got %h want %h", b_md, 16'(rx)); end
        rx++;
      end
      if (b_sv && b_sr) tx++;
      prev_stall = b_mv && !b_mr;
      prev_d = b_md;
    end
    n_checks++; if (rx !== 10000) begin n_fail++; $display("FAIL m1_beats: got %0d want 10000 within budget", rx); end
    b_sv = 1'b0;
    b_mr = 1'b0;
  endtask

  task automatic test_half_rate;
    int tx, rx, hs_win;
    logic mv, mr, sr;
    logic [31:0] md;
    tx = 0; rx = 0; hs_win = 0;
    for (int c = 0; c < 60; c++) begin
      tick;
      f_sv = 1'b1;
      f_sd = 32'h100 + 32'(tx);
      f_mr = (c % 2 == 0);
      #3;
      mv = f_mv; mr = f_mr; sr = f_sr; md = f_md;
      f_mr = ~f_mr;
      #1;
      n_checks++; if (f_sr !== sr) begin n_fail++; $display("FAIL comb_path c=%0d: s_ready went %b -> %b on m_ready flip", c, sr, f_sr); end
      f_mr = ~f_mr;
      #1;
      n_checks++; if (f_occ > 4'd8 || f_occ !== 4'(tx - rx)) begin n_fail++; $display("FAIL half_occ c=%0d: got %0d want %0d", c, f_occ, tx - rx); end
      if (mv && mr) begin
        n_checks++; if (md !== 32'h100 + 32'(rx)) begin n_fail++; $display("FAIL half_order: got %h want %h", md, 32'h100 + 32'(rx)); end
        rx++;
        if (c >= 30) hs_win++;
      end
      if (sr) tx++;
    end
    n_checks++; if (hs_win !== 15) begin n_fail++; $display("FAIL half_throughput: got %0d beats in 30 cycles want 15", hs_win); end
    f_sv = 1'b0;
    f_mr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_sv = 1'b0; a_mr = 1'b0; a_sd = '0;
    b_sv = 1'b0; b_mr = 1'b0; b_sd = '0;
    c_sv = 1'b0; c_mr = 1'b0; c_sd = '0;
    e_sv = 1'b0; e_mr = 1'b0; e_sd = '0;
    f_sv = 1'b0; f_mr = 1'b0; f_sd = '0;
    test_reset;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    test_passthrough;
    test_random_mode1;
    test_half_rate;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/handshake_pipeline.md
Name: handshake_pipeline

Overview:
Parametrised valid/ready pipeline: D register stages carrying a W-bit payload, with full AXI-style backpressure at every stage. It supersedes plain delay-line pipelining on AXI channel paths, where stalls must not drop or duplicate beats. MODE selects bypass, forward-registered or fully-registered (skid) stages. An occupancy counter is exported for debug and credit logic.

Parameters:
W, 32, payload width in bits (>=1)
D, 2, number of pipeline stages (>=0); D=0 means combinational pass-through
MODE, 2, stage type: 0 = bypass (all stages wire-through regardless of D), 1 = forward-registered (valid/data registered, ready combinational), 2 = full slice (valid/data and ready registered, 2-entry skid per stage)
CW, derived localparam = max(1, $clog2(2*D+1)), occupancy width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream beat valid
s_ready  out  1  pipeline accepts beat when s_valid && s_ready
s_data  in  W  upstream payload
m_valid  out  1  downstream beat valid
m_ready  in  1  downstream accepts beat when m_valid && m_ready
m_data  out  W  downstream payload
occupancy  out  CW  beats currently held inside the pipeline

Behaviour:
- Reset (rst_n low, asynchronous assert, deassert synchronised externally): all stage valids 0, all data/skid registers 0, occupancy 0, m_valid 0, m_data 0.
- MODE 2: s_ready is 0 during reset and rises at the first clk edge after deassert.
- MODE 1: s_ready is 1 after reset (stage empty).
- D=0 or MODE=0: s_ready=m_ready, m_valid=s_valid, m_data=s_data, occupancy constant 0, no registers inferred.
- Stages are chained: stage i output feeds stage i+1 input; stage 0 input = s_*, stage D-1 output = m_*.
- MODE 1 stage: in_ready = ~out_valid | out_ready.
  - On in handshake: out_data<=in_data, out_valid<=1.
  - Else on out handshake: out_valid<=0.
  - Capacity 1 beat per stage.
- MODE 2 stage: per-stage FSM EMPTY -> BUSY -> FULL. in_ready is registered, =1 in EMPTY/BUSY and 0 in FULL.
  - EMPTY: in handshake -> BUSY (main<=in).
  - BUSY: in only -> main<=in (out_ready=1) or FULL (out_ready=0, skid<=in); out only -> EMPTY; both -> stay BUSY, main<=in.
  - FULL: out handshake -> BUSY, main<=skid; no in handshake possible.
  - Capacity 2 beats per stage.
- Latency from accepted beat to m_valid with no stall: D cycles (both modes).
- Throughput: one beat per cycle sustained when m_ready held 1.
- AXI rules: m_valid, once high, stays high and m_data stays stable until m_ready. Beats are never dropped, duplicated or reordered. m_valid never depends combinationally on m_ready.
- MODE 2: no combinational path from m_ready to s_ready.
- occupancy: +1 on s handshake, -1 on m handshake, unchanged if both or neither in a cycle. Max D (MODE 1) or 2*D (MODE 2). It is never driven out of range.
- Reset mid-transfer: all held beats are discarded, occupancy 0, and resumes per the reset rules above.

Test Plan:
- D=2, MODE=2, W=32, m_ready=1, send 0x1..0x8 back-to-back -> m_data 0x1..0x8 on consecutive cycles, first m_valid 2 cycles after first accept, occupancy peaks at 2.
- D=2, MODE=2, m_ready=0, stream 0xA0.. -> exactly 4 beats accepted, s_ready 0 from next cycle, occupancy=4. Release m_ready -> beats 0xA0..0xA3 emitted in order, none lost.
- D=3, MODE=1, random s_valid/m_ready (seeded, 10k beats, incrementing payload) -> scoreboard exact in-order match. occupancy never exceeds 3. m_data stable whenever m_valid && !m_ready.
- D=0 (and separately MODE=0, D=4): toggle s_valid/m_ready every cycle -> outputs equal inputs in the same cycle, occupancy 0.
- D=2, MODE=2: fill to occupancy 4, pull rst_n low mid-cycle -> m_valid=0 and occupancy=0 immediately (async). s_ready stays 0 until first edge after deassert. Next beat 0x55 emerges 2 cycles after accept.
- D=4, MODE=2, m_ready pattern 1,0,1,0 with continuous s_valid -> sustained throughput 0.5 beat/cycle, occupancy settles at or below 8. Check no combinational path m_ready->s_ready.
